// File: rtl/eth_phy_mdio_ctrl.sv
// Clause-22 MDIO management controller for the SGMII PHY: hardware-reset
// sequencing, three fixed configuration writes, then periodic reads of reg 1.
module eth_phy_mdio_ctrl #(
    parameter int         CLK_DIV       = 50,
    parameter logic [4:0] PHY_ADDR      = 5'd7,
    parameter int         RESET_HOLD    = 200000,
    parameter int         RESET_WAIT    = 1000000,
    parameter int         POLL_INTERVAL = 5000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        restart,
    output logic        eth_reset_n,
    output logic        eth_mdc,
    output logic        eth_mdio_o,
    input  logic        eth_mdio_i,
    output logic        eth_mdio_t,
    output logic        init_done,
    output logic        link_up,
    output logic [15:0] phy_status,
    output logic        err
);
    localparam int TMAX_HW = (RESET_HOLD > RESET_WAIT) ? RESET_HOLD : RESET_WAIT;
    localparam int TMAX    = (TMAX_HW > POLL_INTERVAL) ? TMAX_HW : POLL_INTERVAL;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int DW      = $clog2(2 * CLK_DIV);

    localparam logic [TW-1:0] HOLD_LAST  = TW'(RESET_HOLD - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(RESET_WAIT - 1);
    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_INTERVAL - 1);
    localparam logic [DW-1:0] DIV_SAMPLE = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLK_DIV - 1);
    localparam logic [5:0]    BIT_TA     = 6'd46;
    localparam logic [5:0]    BIT_LAST   = 6'd63;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_RST_WAIT,
        ST_CFG,
        ST_POLL_WAIT,
        ST_POLL_RD
    } state_t;

    function automatic logic [4:0] cfg_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_reg = 5'd27;
            2'd1:    cfg_reg = 5'd0;
            2'd2:    cfg_reg = 5'd4;
            default: cfg_reg = 5'd0;
        endcase
    endfunction

    function automatic logic [15:0] cfg_data(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_data = 16'h848B;
            2'd1:    cfg_data = 16'h9140;
            2'd2:    cfg_data = 16'h01E1;
            default: cfg_data = 16'h0000;
        endcase
    endfunction

    // Read frames leave TA/DATA as ones so mdio_o idles high while released.
    function automatic logic [63:0] build_frame(input logic rd, input logic [4:0] regad,
                                                input logic [15:0] data);
        build_frame = {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), PHY_ADDR, regad,
                       (rd ? 18'h3_FFFF : {2'b10, data})};
    endfunction

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [DW-1:0]   div_q, div_d;
    logic [5:0]      bit_q, bit_d;
    logic [1:0]      idx_q, idx_d;
    logic [16:0]     rd_q, rd_d;
    logic            init_q, init_d;
    logic            link_q, link_d;
    logic [15:0]     stat_q, stat_d;
    logic            err_q, err_d;
    logic            rstn_q, rstn_d;
    logic            mdc_q, mdc_d;
    logic            mdo_q, mdo_d;
    logic            mdt_q, mdt_d;
    logic            in_frame_s, frame_end_s, in_frame_d_s, rd_frame_s;
    logic [63:0]     frame_s;

    // Next-state: sequencing FSM, shared timer, bit engine and read capture.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        div_d       = div_q;
        bit_d       = bit_q;
        idx_d       = idx_q;
        rd_d        = rd_q;
        init_d      = init_q;
        link_d      = link_q;
        stat_d      = stat_q;
        err_d       = 1'b0;
        in_frame_s  = (state_q == ST_CFG) || (state_q == ST_POLL_RD);
        frame_end_s = in_frame_s && (bit_q == BIT_LAST) && (div_q == DIV_LAST);

        if (in_frame_s) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                bit_d = bit_q + 6'd1;
            end else begin
                div_d = div_q + DW'(1);
            end
            // Last 17 samples end up as {TA bit 2, DATA[15:0]}.
            if (div_q == DIV_SAMPLE) begin
                rd_d = {rd_q[15:0], eth_mdio_i};
            end else begin
                rd_d = rd_q;
            end
        end else begin
            div_d = div_q;
        end

        case (state_q)
            ST_RST_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    state_d = ST_RST_WAIT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_RST_WAIT: begin
                if (tmr_q == WAIT_LAST) begin
                    state_d = ST_CFG;
                    tmr_d   = '0;
                    idx_d   = 2'd0;
                    div_d   = '0;
                    bit_d   = 6'd0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_CFG: begin
                if (frame_end_s && (idx_q == 2'd2)) begin
                    init_d  = 1'b1;
                    state_d = ST_POLL_WAIT;
                    tmr_d   = '0;
                end else if (frame_end_s) begin
                    idx_d = idx_q + 2'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_POLL_WAIT: begin
                if (tmr_q == POLL_LAST) begin
                    state_d = ST_POLL_RD;
                    tmr_d   = '0;
                    div_d   = '0;
                    bit_d   = 6'd0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_POLL_RD: begin
                if (frame_end_s && rd_q[16]) begin
                    state_d = ST_POLL_WAIT;
                    err_d   = 1'b1;
                    link_d  = 1'b0;
                end else if (frame_end_s) begin
                    state_d = ST_POLL_WAIT;
                    stat_d  = rd_q[15:0];
                    link_d  = rd_q[2];
                end else begin
                    state_d = ST_POLL_RD;
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
                tmr_d   = '0;
            end
        endcase

        if (restart) begin
            state_d = ST_RST_HOLD;
            tmr_d   = '0;
            div_d   = '0;
            bit_d   = 6'd0;
            idx_d   = 2'd0;
            init_d  = 1'b0;
            link_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            err_d = err_d;
        end
    end

    // Output decode from next-state so pins line up with the bit counters.
    always_comb begin
        rd_frame_s   = (state_d == ST_POLL_RD);
        in_frame_d_s = (state_d == ST_CFG) || rd_frame_s;
        frame_s      = build_frame(rd_frame_s, rd_frame_s ? 5'd1 : cfg_reg(idx_d), cfg_data(idx_d));
        rstn_d       = (state_d != ST_RST_HOLD);
        if (in_frame_d_s) begin
            mdc_d = (div_d >= DIV_HALF);
            mdo_d = frame_s[BIT_LAST - bit_d];
            mdt_d = rd_frame_s && (bit_d >= BIT_TA);
        end else begin
            mdc_d = 1'b0;
            mdo_d = 1'b1;
            mdt_d = 1'b1;
        end
    end

    // State and output registers; reset clears status, restart keeps it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RST_HOLD;
            tmr_q   <= '0;
            div_q   <= '0;
            bit_q   <= 6'd0;
            idx_q   <= 2'd0;
            rd_q    <= 17'd0;
            init_q  <= 1'b0;
            link_q  <= 1'b0;
            stat_q  <= 16'd0;
            err_q   <= 1'b0;
            rstn_q  <= 1'b0;
            mdc_q   <= 1'b0;
            mdo_q   <= 1'b1;
            mdt_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            init_q  <= init_d;
            link_q  <= link_d;
            stat_q  <= stat_d;
            err_q   <= err_d;
            rstn_q  <= rstn_d;
            mdc_q   <= mdc_d;
            mdo_q   <= mdo_d;
            mdt_q   <= mdt_d;
        end
    end

    assign eth_reset_n = rstn_q;
    assign eth_mdc     = mdc_q;
    assign eth_mdio_o  = mdo_q;
    assign eth_mdio_t  = mdt_q;
    assign init_done   = init_q;
    assign link_up     = link_q;
    assign phy_status  = stat_q;
    assign err         = err_q;

endmodule

// File: tb/tb_eth_phy_mdio_ctrl.sv
// Bench for eth_phy_mdio_ctrl: a PHY model decodes frames on MDC rising edges
// and answers reg-1 reads; expectations come from the frame format and table.
module tb_eth_phy_mdio_ctrl;
    localparam int CLK_DIV       = 2;
    localparam int RESET_HOLD    = 10;
    localparam int RESET_WAIT    = 20;
    localparam int POLL_INTERVAL = 100;
    localparam int BIT_CYC       = 2 * CLK_DIV;
    localparam int FRAME_CYC     = 64 * BIT_CYC;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic        eth_mdio_i;
    logic        eth_reset_n, eth_mdc, eth_mdio_o, eth_mdio_t, init_done, link_up, err;
    logic [15:0] phy_status;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    eth_phy_mdio_ctrl #(
        .CLK_DIV(CLK_DIV), .PHY_ADDR(5'd7), .RESET_HOLD(RESET_HOLD),
        .RESET_WAIT(RESET_WAIT), .POLL_INTERVAL(POLL_INTERVAL)
    ) dut (
        .clock(clock), .reset(reset), .restart(restart), .eth_reset_n(eth_reset_n),
        .eth_mdc(eth_mdc), .eth_mdio_o(eth_mdio_o), .eth_mdio_i(eth_mdio_i),
        .eth_mdio_t(eth_mdio_t), .init_done(init_done), .link_up(link_up),
        .phy_status(phy_status), .err(err)
    );

    // Captured frames (mdio_o and mdio_t per bit) with MDC-rise cycle stamps.
    logic [63:0] frames[$];
    logic [63:0] tvecs[$];
    int          starts[$];
    int          ends[$];
    logic [63:0] cur_o, cur_t;
    int          bitcnt, cyc, start_cyc, err_hi, init_rise;
    logic        mdc_prev, init_prev;
    logic        phy_present;
    logic [15:0] phy_resp;

    logic [4:0]  cfg_reg [3] = '{5'd27, 5'd0, 5'd4};
    logic [15:0] cfg_dat [3] = '{16'h848B, 16'h9140, 16'h01E1};

    logic [15:0] exp_status;
    logic        exp_link;
    int          lowcnt;
    logic        mdc_seen, rstn_seen_lo;
    int          base;
    logic [15:0] r;

    // PHY model and bus monitor.
    initial begin : phy_model
        bitcnt = 0; cyc = 0; start_cyc = 0; err_hi = 0; init_rise = -1;
        mdc_prev = 1'b0; init_prev = 1'b0; eth_mdio_i = 1'b1;
        cur_o = 64'd0; cur_t = 64'd0;
        forever begin
            @(negedge clock);
            cyc = cyc + 1;
            if (err === 1'b1) err_hi = err_hi + 1;
            if (init_done === 1'b1 && !init_prev) init_rise = cyc;
            init_prev = (init_done === 1'b1);
            if (eth_reset_n !== 1'b1) begin
                bitcnt = 0;
                eth_mdio_i = 1'b1;
            end else if (eth_mdc === 1'b1 && !mdc_prev) begin
                cur_o[63 - bitcnt] = eth_mdio_o;
                cur_t[63 - bitcnt] = eth_mdio_t;
                if (bitcnt == 0) start_cyc = cyc;
                if (bitcnt == 63) begin
                    frames.push_back(cur_o);
                    tvecs.push_back(cur_t);
                    starts.push_back(start_cyc);
                    ends.push_back(cyc);
                    bitcnt = 0;
                end else begin
                    bitcnt = bitcnt + 1;
                end
                if (bitcnt >= 47 && cur_o[29:28] == 2'b10 && phy_present)
                    eth_mdio_i = (bitcnt == 47) ? 1'b0 : phy_resp[63 - bitcnt];
                else
                    eth_mdio_i = 1'b1;
            end
            mdc_prev = (eth_mdc === 1'b1);
        end
    end

    function automatic logic [63:0] wr_frame(input logic [4:0] ra, input logic [15:0] d);
        return {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd7, ra, 2'b10, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("frame_timeout", 64'(frames.size() >= n), 64'd1);
    endtask

    task automatic check_reset_vals(input logic [15:0] st);
        chk("rst_eth_reset_n", eth_reset_n, 1'b0);
        chk("rst_mdc", eth_mdc, 1'b0);
        chk("rst_mdio_o", eth_mdio_o, 1'b1);
        chk("rst_mdio_t", eth_mdio_t, 1'b1);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_phy_status", phy_status, st);
        chk("rst_err", err, 1'b0);
    endtask

    task automatic check_cfg(input int b);
        wait_frames(b + 3, 3000);
        repeat (4) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk("cfg_frame", frames[b + i], wr_frame(cfg_reg[i], cfg_dat[i]));
            chk("cfg_mdio_t", tvecs[b + i], 64'd0);
            chk("bit_period", 64'(ends[b + i] - starts[b + i]), 64'(63 * BIT_CYC));
        end
        for (int i = 1; i < 3; i++)
            chk("cfg_gap", 64'(starts[b + i] - starts[b + i - 1]), 64'(FRAME_CYC));
        chk("init_done", init_done, 1'b1);
        chk("init_rise", 64'(init_rise - ends[b + 2]), 64'(CLK_DIV));
    endtask

    task automatic do_poll(input logic present, input logic [15:0] resp);
        int n  = frames.size();
        int e0 = err_hi;
        phy_present = present;
        phy_resp    = resp;
        wait_frames(n + 1, 1000);
        repeat (4) @(negedge clock);
        chk("rd_header", 64'(frames[n][63:18]), 64'({32'hFFFF_FFFF, 2'b01, 2'b10, 5'd7, 5'd1}));
        chk("rd_mdio_t", tvecs[n], 64'h3_FFFF);
        chk("poll_gap", 64'(starts[n] - starts[n - 1]), 64'(FRAME_CYC + POLL_INTERVAL));
        if (present) begin
            exp_status = resp;
            exp_link   = resp[2];
        end else begin
            exp_link = 1'b0;
        end
        chk("phy_status", phy_status, exp_status);
        chk("link_up", link_up, exp_link);
        chk("err_pulses", 64'(err_hi - e0), present ? 64'd0 : 64'd1);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
    endtask

    initial begin
        phy_present = 1'b1;
        phy_resp    = 16'h0000;
        exp_status  = 16'h0000;
        exp_link    = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_reset_vals(16'h0000);

        lowcnt = 0;
        while (eth_reset_n === 1'b0 && lowcnt < 50) begin
            lowcnt++;
            @(negedge clock);
        end
        chk("rst_hold_len", 64'(lowcnt), 64'(RESET_HOLD));
        mdc_seen = 1'b0;
        rstn_seen_lo = 1'b0;
        repeat (RESET_WAIT) begin
            mdc_seen     = mdc_seen | (eth_mdc !== 1'b0);
            rstn_seen_lo = rstn_seen_lo | (eth_reset_n !== 1'b1);
            @(negedge clock);
        end
        chk("wait_mdc_quiet", mdc_seen, 1'b0);
        chk("wait_rstn_high", rstn_seen_lo, 1'b0);

        check_cfg(0);

        do_poll(1'b1, 16'h796D);
        do_poll(1'b1, 16'h7969);
        for (int i = 0; i < 3; i++) begin
            r = 16'($urandom);
            if (i == 2) r[2] = 1'b1;
            do_poll(1'b1, r);
        end

        do_poll(1'b0, 16'hFFFF);
        do_poll(1'b0, 16'hFFFF);

        base = frames.size();
        pulse_restart();
        exp_link = 1'b0;
        wait_frames(base + 1, 2000);
        repeat (30 * BIT_CYC) @(negedge clock);
        pulse_restart();
        chk("rs_eth_reset_n", eth_reset_n, 1'b0);
        chk("rs_mdc", eth_mdc, 1'b0);
        chk("rs_mdio_t", eth_mdio_t, 1'b1);
        chk("rs_init_done", init_done, 1'b0);
        chk("rs_link_up", link_up, 1'b0);
        chk("rs_phy_status", phy_status, exp_status);
        check_cfg(frames.size());

        r = 16'($urandom) | 16'h0004;
        do_poll(1'b1, r);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals(16'h0000);
        reset = 1'b0;
        exp_status = 16'h0000;
        exp_link   = 1'b0;
        check_cfg(frames.size());
        do_poll(1'b1, 16'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_phy_mdio_ctrl.md
Name: eth_phy_mdio_ctrl

Overview:
Management controller for the external Ethernet PHY behind the SGMII link. After reset it holds the PHY in hardware reset, releases it, and waits for the PHY to settle. It then issues a fixed sequence of Clause-22 MDIO writes to configure the PHY for SGMII. Afterwards it polls link status periodically. It drives the eth_mdc pin and the eth_mdio_o/_i/_t IOBUF triple, and exports init/link/error status to main_minimal_interface.

Parameters:
CLK_DIV, 50, MDC half-period in clock cycles (MDC = clock/(2*CLK_DIV)); minimum 2
PHY_ADDR, 5'd7, Clause-22 PHY address
RESET_HOLD, 200000, cycles eth_reset_n held low
RESET_WAIT, 1000000, cycles after eth_reset_n release before the first frame
POLL_INTERVAL, 5000000, idle cycles between link-status reads

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
restart  in  1  1-cycle pulse; reruns the full sequence
eth_reset_n  out  1  PHY hardware reset, active-low
eth_mdc  out  1  MDIO clock
eth_mdio_o  out  1  MDIO output to IOBUF
eth_mdio_i  in  1  MDIO input from IOBUF
eth_mdio_t  out  1  IOBUF tristate; 1 = high-Z
init_done  out  1  high once all config writes are complete; sticky
link_up  out  1  bit 2 of last valid reg 1 read
phy_status  out  16  data from last valid reg 1 read
err  out  1  1-cycle pulse when a read has a bad turnaround

Behaviour:
- Reset values: eth_reset_n=0, eth_mdc=0, eth_mdio_o=1, eth_mdio_t=1, init_done=0, link_up=0, phy_status=0, err=0.
- reset or restart: FSM enters RST_HOLD on the next edge. Any in-flight frame is aborted with mdc=0 and mdio_t=1. init_done and link_up clear. phy_status is kept on restart and cleared on reset.
- FSM states:
  - RST_HOLD: eth_reset_n=0 for RESET_HOLD cycles, then go to RST_WAIT.
  - RST_WAIT: eth_reset_n=1, count RESET_WAIT cycles, then go to CFG with idx=0.
  - CFG: send write frame for table[idx]. On frame end, idx++. After idx=2, set init_done=1 and go to POLL_WAIT.
  - POLL_WAIT: count POLL_INTERVAL cycles, then go to POLL_RD.
  - POLL_RD: send read of reg 1, update status, return to POLL_WAIT.
- Config table (reg, data): (27, 0x848B) SGMII mode without clock; (0, 0x9140) soft reset + AN enable + 1000FD; (4, 0x01E1).
- Frame format: 64 bits, MSB first.
  - 32 preamble 1s, ST=01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0].
  - TA: write = 10 driven; read = 2 bits high-Z.
  - DATA[15:0]: write = driven; read = high-Z.
- Bit timing:
  - Each bit is 2*CLK_DIV cycles: eth_mdc low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - eth_mdio_o/_t update on the first low-phase cycle.
  - eth_mdio_i is sampled on the last low-phase cycle (the cycle before MDC rises).
- Idle between frames: mdc=0, mdio_t=1, mdio_o=1. Frames are back-to-back in CFG with no gap.
- Read drive: mdio_t=1 from the first TA bit through DATA[0]. mdio_t=0 for the whole of every write frame, and for read frames up to the end of REGAD.
- Read validity: the sample at TA bit 2 must be 0.
  - If 1: err pulses 1 cycle after frame end, link_up=0, phy_status is unchanged.
  - Otherwise: phy_status<=DATA and link_up<=DATA[2], both 1 cycle after frame end.
- Counters are sized by $clog2 of their parameter. The timing counter saturates by reload, with no wrap across states.

Test Plan:
(Simulation parameters: CLK_DIV=2, RESET_HOLD=10, RESET_WAIT=20, POLL_INTERVAL=100, PHY_ADDR=7)
1. Release reset -> eth_reset_n low exactly 10 cycles, then high; eth_mdc stays 0 for the next 20 cycles; outputs match reset values.
2. First frame, sampled at MDC rising edges -> 32x1, 01, 01, 00111, 11011, 10, 0x848B. Bit period is 4 cycles, mdio_t=0 throughout, and the next two frames follow with 0x9140 and 0x01E1. init_done rises after the 3rd frame.
3. PHY model answers reg 1 with TA=0 and 0x796D -> phy_status=0x796D, link_up=1. Next poll returns 0x7969 -> link_up=0, with polls 100 idle cycles apart.
4. mdio_i held high (no PHY) -> err pulses once per poll, link_up=0, phy_status holds its prior value, and mdio_t=1 during TA/DATA.
5. restart pulse mid-way through write frame 2 -> next cycle: eth_reset_n=0, mdc=0, mdio_t=1, init_done=0. The full sequence then reruns from idx 0.
6. reset asserted during POLL_WAIT with link_up=1 -> all outputs return to reset values on the next edge, and the sequence restarts cleanly after release.
